tristate_bus_receiver: RTL and testbench
========================================

TRISTATE_BUS_RECEIVER -- requirements
Module: tristate_bus_receiver

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port line_in, input, 1 bit: shared tri-state serial line, pulled up, so idle reads 1.
REQ-005 SHALL have port rx_data, output, 8 bits: received byte.
REQ-006 SHALL have port rx_valid, output, 1 bit: rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready, input, 1 bit: consumer accepts rx_data when rx_valid && rx_ready.
REQ-008 SHALL have port frame_err, output, 1 bit: one-cycle pulse when the stop bit is 0.
REQ-009 SHALL have port overrun, output, 1 bit: one-cycle pulse when a completed byte is dropped.

Function
REQ-010 SHALL pass line_in through a 2-flop synchronizer; all decisions SHALL use the synchronized value (line_s).
REQ-011 SHALL implement the states IDLE, START, DATA, STOP and WAIT_IDLE, with a bit-timing counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-012 In IDLE, line_s == 0 SHALL move to START with the counter cleared.
REQ-013 In START, when the counter reaches CLKS_PER_BIT/2-1, line_s SHALL be sampled at mid-bit.
  - If the sample is 1: false start; return to IDLE, no outputs.
  - If the sample is 0: go to DATA with the counter and bit index cleared.
REQ-014 In DATA, each time the counter reaches CLKS_PER_BIT-1:
  - line_s SHALL be sampled into shift-register bit [index], LSB first;
  - the counter SHALL wrap to 0;
  - after index 7, the state SHALL go to STOP.
REQ-015 In STOP, when the counter reaches CLKS_PER_BIT-1:
  - a sample of 1 SHALL deliver the byte (REQ-016) and return to IDLE;
  - a sample of 0 SHALL pulse frame_err for 1 cycle, discard the byte and go to WAIT_IDLE.
REQ-016 Delivery SHALL be decided from the rx_valid/rx_ready state in the same cycle:
  - If rx_valid == 0, or rx_valid && rx_ready: rx_data <= byte and rx_valid <= 1.
  - If rx_valid && !rx_ready: the held byte is kept, the new byte is dropped, and overrun pulses for 1 cycle.
REQ-017 rx_valid SHALL clear on the cycle after a handshake unless a delivery occurs in that same handshake cycle.
REQ-018 rx_data SHALL stay stable while rx_valid == 1 and no handshake has occurred.
REQ-019 WAIT_IDLE SHALL return to IDLE only once line_s == 1, which blocks false starts on a held-low or contended line.
REQ-020 Latency: rx_valid SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first clk edge that samples line_in == 0; for a full frame with CLKS_PER_BIT=16 this is 154 cycles.
REQ-021 A line_in glitch shorter than CLKS_PER_BIT/2-1 cycles SHALL be rejected as a false start.
REQ-022 Back-to-back frames, meaning a stop bit immediately followed by a start bit, SHALL be received without loss.

Reset
REQ-023 While rst == 1 at a clock edge, the block SHALL set:
  - state = IDLE, counter = 0, index = 0;
  - synchronizer flops = 1;
  - rx_data = 8'h00, rx_valid = 0, frame_err = 0, overrun = 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; no delivery, frame_err or overrun SHALL result from the aborted frame.

Verification (CLKS_PER_BIT=16)
REQ-025 Send frame 8'hA5 with rx_ready=1 -> rx_valid=1 and rx_data=8'hA5 at cycle 154 (±0) after the start edge; rx_valid=0 on the next cycle.
REQ-026 Pull line_in low for 5 cycles, then release -> returns to IDLE; rx_valid, frame_err and overrun all stay 0.
REQ-027 Send frame 8'h3C with a stop bit of 0 -> frame_err pulses exactly 1 cycle and rx_valid stays 0; with line_in held 0 for a further 100 cycles, no new frame starts.
REQ-028 With rx_ready=0, send 8'h11 then 8'h22 back-to-back -> rx_data=8'h11 with rx_valid=1, and a 1-cycle overrun pulse at the end of the second frame; raising rx_ready then clears rx_valid.
REQ-029 Assert rst for 1 cycle during DATA bit 4 of 8'hFF, then send 8'h5A -> no output from the first frame; the second frame delivers rx_data=8'h5A.
REQ-030 Send 8'h01, 8'h80, 8'hFF back-to-back with rx_ready=1 -> three deliveries in order, no errors.

Source files
------------

// File: rtl/tristate_bus_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tristate_bus_receiver
//  Description : 8N1 serial receiver for a pulled-up shared line, with
//                ready/valid byte output and frame-error/overrun pulses.
//  Revision    : 1.0
// ============================================================================
module tristate_bus_receiver #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_full_m1 = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_m1 = c_cnt_w'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_nxt;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_nxt;
    logic               r_sync1;
    logic               r_line_s;
    logic               w_deliver;
    logic               w_ferr;
    logic [7:0]         r_rx_data;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_overrun;

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_line_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // Mid-bit check rejects short glitches as false starts
                if (r_cnt == c_half_m1) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_line_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_full_m1) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = r_line_s;
                    w_idx_nxt          = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == c_full_m1) begin
                    w_cnt_nxt = '0;
                    if (r_line_s) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                w_cnt_nxt = '0;
                if (r_line_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_sync1     <= 1'b1;
            r_line_s    <= 1'b1;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1     <= line_in;
            r_line_s    <= r_sync1;
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_ferr;
            r_overrun   <= 1'b0;
            // A handshake in the delivery cycle frees the slot for the new byte
            if (w_deliver) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_data  <= r_shift;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tristate_bus_receiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tristate_bus_receiver
//  Description : Randomized, self-checking bench for tristate_bus_receiver.
//  Revision    : 1.0
// ============================================================================
module tb_tristate_bus_receiver;

    localparam int CLKS_PER_BIT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_in = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int passed = 0;
    int total  = 0;
    int cyc = 0;
    int last_rise = -1;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int vhi_cnt = 0;
    logic prev_valid = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    tristate_bus_receiver #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .line_in  (line_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle: handshakes, rising edges and pulse widths
    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
        if (rx_valid && !prev_valid) last_rise = cyc;
        if (rx_valid) vhi_cnt++;
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        prev_valid = rx_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        line_in = b;
        repeat (CLKS_PER_BIT) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        line_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        line_in = 1'b1;
        rx_ready = 1'b0;
        repeat (3) tick();
        total++;
        if (rx_data !== 8'h00) begin
            $display("FAIL reset_rx_data: got %h expected 00", rx_data);
        end else passed++;
        total++;
        if (rx_valid !== 1'b0) begin
            $display("FAIL reset_rx_valid: got %b expected 0", rx_valid);
        end else passed++;
        total++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            $display("FAIL reset_pulses: got ferr=%b ovr=%b expected 0 0", frame_err, overrun);
        end else passed++;
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_latency();
        int start_cyc;
        rx_ready = 1'b1;
        got_q.delete();
        vhi_cnt = 0;
        start_cyc = cyc + 1;
        send_frame(8'hA5, 1'b1);
        repeat (4) tick();
        total++;
        if (last_rise - start_cyc !== 154) begin
            $display("FAIL latency: got %0d cycles expected 154", last_rise - start_cyc);
        end else passed++;
        total++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 8'hA5)) begin
            $display("FAIL basic_data: got %0d bytes first %h expected 1 byte a5",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end else passed++;
        total++;
        if (vhi_cnt !== 1) begin
            $display("FAIL valid_width: got %0d cycles expected 1", vhi_cnt);
        end else passed++;
    endtask

    task automatic test_glitch();
        int f0;
        int o0;
        int lens[2] = '{5, CLKS_PER_BIT / 2 - 2};
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        got_q.delete();
        vhi_cnt = 0;
        foreach (lens[k]) begin
            line_in = 1'b0;
            repeat (lens[k]) tick();
            line_in = 1'b1;
            repeat (3 * CLKS_PER_BIT) tick();
        end
        // A genuine frame right after must still be received
        send_frame(8'h96, 1'b1);
        repeat (4) tick();
        total++;
        if (ferr_cnt !== f0 || ovr_cnt !== o0) begin
            $display("FAIL glitch_pulses: got ferr=%0d ovr=%0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end else passed++;
        total++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 8'h96)) begin
            $display("FAIL glitch_then_frame: got %0d bytes expected 1 byte 96", got_q.size());
        end else passed++;
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = ferr_cnt;
        got_q.delete();
        vhi_cnt = 0;
        send_frame(8'h3C, 1'b0);
        line_in = 1'b0;
        repeat (100) tick();
        line_in = 1'b1;
        repeat (12 * CLKS_PER_BIT) tick();
        total++;
        if (ferr_cnt - f0 !== 1) begin
            $display("FAIL frame_err_width: got %0d cycles expected 1", ferr_cnt - f0);
        end else passed++;
        total++;
        if (vhi_cnt !== 0 || got_q.size() !== 0) begin
            $display("FAIL frame_err_no_data: got valid cycles %0d expected 0", vhi_cnt);
        end else passed++;
    endtask

    task automatic test_overrun();
        int o0;
        int f0;
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        rx_ready = 1'b0;
        got_q.delete();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2) tick();
        total++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
            $display("FAIL overrun_hold: got valid=%b data=%h expected 1 11", rx_valid, rx_data);
        end else passed++;
        total++;
        if (ovr_cnt - o0 !== 1 || ferr_cnt !== f0) begin
            $display("FAIL overrun_pulse: got ovr=%0d ferr=%0d expected 1 0", ovr_cnt - o0, ferr_cnt - f0);
        end else passed++;
        rx_ready = 1'b1;
        repeat (2) tick();
        total++;
        if (rx_valid !== 1'b0 || got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 8'h11)) begin
            $display("FAIL overrun_drain: got valid=%b bytes=%0d expected 0 1", rx_valid, got_q.size());
        end else passed++;
    endtask

    task automatic test_reset_mid_frame();
        int f0;
        int o0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx_ready = 1'b1;
        got_q.delete();
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        line_in = 1'b1;
        repeat (CLKS_PER_BIT / 2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (CLKS_PER_BIT / 2 - 1 + 4 * CLKS_PER_BIT) tick();
        repeat (CLKS_PER_BIT) tick();
        total++;
        if (got_q.size() !== 0 || ferr_cnt !== f0 || ovr_cnt !== o0) begin
            $display("FAIL reset_abort: got bytes=%0d ferr=%0d ovr=%0d expected 0 0 0",
                     got_q.size(), ferr_cnt - f0, ovr_cnt - o0);
        end else passed++;
        send_frame(8'h5A, 1'b1);
        repeat (4) tick();
        total++;
        if (got_q.size() !== 1 || (got_q.size() == 1 && got_q[0] !== 8'h5A)) begin
            $display("FAIL reset_recover: got %0d bytes expected 1 byte 5a", got_q.size());
        end else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[3] = '{8'h01, 8'h80, 8'hFF};
        int f0;
        int o0;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        rx_ready = 1'b1;
        got_q.delete();
        foreach (seq[k]) send_frame(seq[k], 1'b1);
        repeat (4) tick();
        total++;
        if (got_q.size() !== 3) begin
            $display("FAIL b2b_count: got %0d bytes expected 3", got_q.size());
        end else passed++;
        foreach (seq[k]) begin
            total++;
            if (got_q.size() <= k || got_q[k] !== seq[k]) begin
                $display("FAIL b2b_byte%0d: got %h expected %h", k,
                         (got_q.size() > k) ? got_q[k] : 8'hxx, seq[k]);
            end else passed++;
        end
        total++;
        if (ferr_cnt !== f0 || ovr_cnt !== o0) begin
            $display("FAIL b2b_errors: got ferr=%0d ovr=%0d expected 0 0", ferr_cnt - f0, ovr_cnt - o0);
        end else passed++;
    endtask

    task automatic test_random();
        int f0;
        int exp_ferr;
        logic [7:0] b;
        logic stop;
        int gap;
        f0 = ferr_cnt;
        exp_ferr = 0;
        rx_ready = 1'b1;
        got_q.delete();
        exp_q.delete();
        for (int n = 0; n < 16; n++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            if (stop) exp_q.push_back(b);
            else exp_ferr++;
            send_frame(b, stop);
            gap = stop ? $urandom_range(0, 20) : $urandom_range(3, 20);
            repeat (gap) tick();
        end
        repeat (2 * CLKS_PER_BIT) tick();
        total++;
        if (got_q.size() !== exp_q.size()) begin
            $display("FAIL rand_count: got %0d bytes expected %0d", got_q.size(), exp_q.size());
        end else passed++;
        foreach (exp_q[k]) begin
            total++;
            if (got_q.size() <= k || got_q[k] !== exp_q[k]) begin
                $display("FAIL rand_byte%0d: got %h expected %h", k,
                         (got_q.size() > k) ? got_q[k] : 8'hxx, exp_q[k]);
            end else passed++;
        end
        total++;
        if (ferr_cnt - f0 !== exp_ferr) begin
            $display("FAIL rand_ferr: got %0d expected %0d", ferr_cnt - f0, exp_ferr);
        end else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
